// File: rtl/vx_tl_mem_bridge_if.sv
// Core memory req/rsp and TileLink-UH A/D signal bundle for vx_tl_mem_bridge.
// 'slave' is the bridge's view; 'master' is the core/TL environment's view.
interface vx_tl_mem_bridge_if #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 28,
  parameter int TAG_WIDTH     = 15,
  parameter int SOURCE_WIDTH  = 3,
  parameter int TL_ADDR_WIDTH = 32
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                     req_valid;
  logic                     req_rw;
  logic [MASK_WIDTH-1:0]    req_byteen;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_data;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     req_ready;

  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic [TAG_WIDTH-1:0]     rsp_tag;
  logic                     rsp_ready;

  logic                     a_valid;
  logic                     a_ready;
  logic [2:0]               a_opcode;
  logic [2:0]               a_param;
  logic [3:0]               a_size;
  logic [SOURCE_WIDTH-1:0]  a_source;
  logic [TL_ADDR_WIDTH-1:0] a_address;
  logic [MASK_WIDTH-1:0]    a_mask;
  logic [DATA_WIDTH-1:0]    a_data;
  logic                     a_corrupt;

  logic                     d_valid;
  logic                     d_ready;
  logic [2:0]               d_opcode;
  logic [SOURCE_WIDTH-1:0]  d_source;
  logic                     d_denied;
  logic                     d_corrupt;
  logic [DATA_WIDTH-1:0]    d_data;

  modport slave (
    input  req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready,
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_source, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport master (
    output req_valid, req_rw, req_byteen, req_addr, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready,
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_source, d_denied, d_corrupt, d_data,
    input  d_ready
  );
endinterface

// File: rtl/vx_tl_mem_bridge.sv
// Vortex core memory port to TileLink-UH A/D bridge with per-source tag table and MSIP->IRQ stretcher.
// Define VX_TL_A_REG_EN to register the A channel through a 2-entry skid buffer (default: combinational A).
module vx_tl_mem_bridge #(
  parameter int DATA_WIDTH       = 128,
  parameter int ADDR_WIDTH       = 28,
  parameter int TAG_WIDTH        = 15,
  parameter int SOURCE_WIDTH     = 3,
  parameter int TL_ADDR_WIDTH    = 32,
  parameter int IRQ_PULSE_CYCLES = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic msip,
  output logic irq_out,
  output logic busy,
  output logic err_sticky,
  vx_tl_mem_bridge_if.slave bus
);
  localparam int MASK_WIDTH  = DATA_WIDTH / 8;
  localparam int SIZE        = $clog2(MASK_WIDTH);
  localparam int NUM_SOURCES = 2 ** SOURCE_WIDTH;

  localparam logic [2:0] OP_PUT_FULL     = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL  = 3'd1;
  localparam logic [2:0] OP_GET          = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK_D = 3'd1;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [SOURCE_WIDTH-1:0]  source;
    logic [TL_ADDR_WIDTH-1:0] address;
    logic [MASK_WIDTH-1:0]    mask;
    logic [DATA_WIDTH-1:0]    data;
  } a_beat_t;

  logic [NUM_SOURCES-1:0] src_valid;
  logic [TAG_WIDTH-1:0]   src_tag [NUM_SOURCES];
  logic                   free_found;
  logic [SOURCE_WIDTH-1:0] free_id;
  logic                   alloc;
  a_beat_t                req_beat;
  a_beat_t                a_beat;
  logic                   d_hit;
  logic                   d_fire;
  logic                   msip_q;
  logic [3:0]             irq_cnt;

  // Lowest-index free source; a source freed this cycle stays valid until the next edge.
  // NOTE: combinational blocks use blocking assignments with a default first, so no latch is inferred.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (!src_valid[i]) begin
        free_found = 1'b1;
        free_id    = SOURCE_WIDTH'(i);
      end
    end
  end

  always_comb begin
    req_beat.opcode  = !bus.req_rw ? OP_GET : (&bus.req_byteen ? OP_PUT_FULL : OP_PUT_PARTIAL);
    req_beat.source  = free_id;
    req_beat.address = {bus.req_addr, {SIZE{1'b0}}};
    req_beat.mask    = bus.req_rw ? bus.req_byteen : {MASK_WIDTH{1'b1}};
    req_beat.data    = bus.req_data;
  end

`ifdef VX_TL_A_REG_EN
  a_beat_t    skid [2];
  logic [1:0] skid_count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       deq;

  assign bus.req_ready = !reset && (skid_count != 2'd2) && free_found;
  assign bus.a_valid   = !reset && (skid_count != 2'd0);
  assign deq           = bus.a_valid && bus.a_ready;
  assign a_beat        = skid[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      skid_count <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else begin
      if (alloc) wr_ptr <= ~wr_ptr;
      if (deq)   rd_ptr <= ~rd_ptr;
      skid_count <= skid_count + {1'b0, alloc} - {1'b0, deq};
    end
  end

  always_ff @(posedge clock) begin
    if (alloc) skid[wr_ptr] <= req_beat;
  end
`else
  assign bus.req_ready = !reset && bus.a_ready && free_found;
  assign bus.a_valid   = !reset && bus.req_valid && free_found;
  assign a_beat        = req_beat;
`endif

  assign alloc         = bus.req_valid && bus.req_ready;
  assign bus.a_opcode  = a_beat.opcode;
  assign bus.a_param   = 3'd0;
  assign bus.a_size    = 4'(SIZE);
  assign bus.a_source  = a_beat.source;
  assign bus.a_address = a_beat.address;
  assign bus.a_mask    = a_beat.mask;
  assign bus.a_data    = a_beat.data;
  assign bus.a_corrupt = 1'b0;

  // Reads stall D on the core; acks and responses to unknown sources are always taken.
  always_comb begin
    d_hit         = src_valid[bus.d_source];
    bus.rsp_valid = 1'b0;
    bus.d_ready   = !reset;
    if (!reset && d_hit && bus.d_opcode == OP_ACCESS_ACK_D) begin
      bus.rsp_valid = bus.d_valid;
      bus.d_ready   = bus.rsp_ready;
    end
  end

  assign bus.rsp_data = bus.d_data;
  assign bus.rsp_tag  = src_tag[bus.d_source];
  assign d_fire       = bus.d_valid && bus.d_ready;
  assign busy         = |src_valid;
  assign irq_out      = |irq_cnt;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      src_valid  <= '0;
      err_sticky <= 1'b0;
      msip_q     <= 1'b0;
      irq_cnt    <= 4'd0;
    end else begin
      if (d_fire && d_hit) src_valid[bus.d_source] <= 1'b0;
      if (alloc)           src_valid[free_id]      <= 1'b1;
      if (d_fire && (!d_hit || bus.d_denied || bus.d_corrupt)) err_sticky <= 1'b1;
      msip_q <= msip;
      if (msip && !msip_q)     irq_cnt <= 4'(IRQ_PULSE_CYCLES);
      else if (irq_cnt != 4'd0) irq_cnt <= irq_cnt - 4'd1;
    end
  end

  // NOTE: the tag table is not reset; an entry is only read while its valid bit is set.
  always_ff @(posedge clock) begin
    if (alloc) src_tag[free_id] <= bus.req_tag;
  end
endmodule

// File: tb/tb_vx_tl_mem_bridge.sv
// Self-checking bench for vx_tl_mem_bridge (combinational A build): directed scenarios plus a
// randomized run against a source-table model kept as plain arrays.
module tb_vx_tl_mem_bridge;
  localparam int NS = 8;
  localparam int PULSE = 6;

  logic clock = 1'b0;
  logic reset, msip, irq_out, busy, err_sticky;
  always #5 clock = ~clock;

  vx_tl_mem_bridge_if #(.DATA_WIDTH(128), .ADDR_WIDTH(28), .TAG_WIDTH(15),
                        .SOURCE_WIDTH(3), .TL_ADDR_WIDTH(32)) bus ();

  vx_tl_mem_bridge dut (
    .clock(clock), .reset(reset), .msip(msip), .irq_out(irq_out),
    .busy(busy), .err_sticky(err_sticky), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  bit          m_valid [NS];
  logic [14:0] m_tag   [NS];
  bit          m_rw    [NS];

  function automatic int lowest_free();
    for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit any_busy();
    for (int i = 0; i < NS; i++) if (m_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 0; bus.req_rw = 0; bus.req_byteen = '0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_tag = '0; bus.rsp_ready = 0; bus.a_ready = 0;
    bus.d_valid = 0; bus.d_opcode = 0; bus.d_source = 0; bus.d_denied = 0;
    bus.d_corrupt = 0; bus.d_data = '0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1;
    repeat (cycles) tick();
    reset = 0;
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
  endtask

  task automatic drive_read(input logic [27:0] addr, input logic [14:0] tag);
    bus.req_valid = 1; bus.req_rw = 0; bus.req_byteen = '0;
    bus.req_addr = addr; bus.req_tag = tag; bus.req_data = '0;
  endtask

  task automatic model_alloc(input int id, input logic [14:0] tag, input bit rw);
    m_valid[id] = 1; m_tag[id] = tag; m_rw[id] = rw;
  endtask

  task automatic test_reset();
    idle();
    msip = 0;
    reset = 1;
    bus.req_valid = 1; bus.a_ready = 1; bus.d_valid = 1; bus.d_opcode = 1; bus.rsp_ready = 1;
    tick();
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got %b exp 0", bus.req_ready); end
    vectors++; if (bus.a_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid got %b exp 0", bus.a_valid); end
    vectors++; if (bus.d_ready !== 1'b0) begin miscompares++; $display("FAIL reset_d_ready got %b exp 0", bus.d_ready); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    tick();
    idle();
    reset = 0;
    for (int i = 0; i < NS; i++) m_valid[i] = 0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (irq_out !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", irq_out); end
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", err_sticky); end
  endtask

  task automatic test_read();
    int id;
    logic [127:0] rd;
    idle();
    bus.a_ready = 1;
    id = lowest_free();
    drive_read(28'h40, 15'h12);
    #1;
    vectors++; if (bus.a_valid !== 1'b1) begin miscompares++; $display("FAIL read_a_valid got %b exp 1", bus.a_valid); end
    vectors++; if (bus.a_opcode !== 3'd4) begin miscompares++; $display("FAIL read_opcode got %0d exp 4", bus.a_opcode); end
    vectors++; if (bus.a_address !== 32'h400) begin miscompares++; $display("FAIL read_address got %h exp 00000400", bus.a_address); end
    vectors++; if (bus.a_size !== 4'd4) begin miscompares++; $display("FAIL read_size got %0d exp 4", bus.a_size); end
    vectors++; if (bus.a_mask !== 16'hFFFF) begin miscompares++; $display("FAIL read_mask got %h exp ffff", bus.a_mask); end
    vectors++; if (bus.a_source !== 3'(id)) begin miscompares++; $display("FAIL read_source got %0d exp %0d", bus.a_source, id); end
    tick();
    model_alloc(id, 15'h12, 0);
    idle();
    rd = rnd128();
    bus.d_valid = 1; bus.d_opcode = 1; bus.d_source = 3'(id); bus.d_data = rd; bus.rsp_ready = 1;
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy_set got %b exp 1", busy); end
    vectors++; if (bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL read_rsp_valid got %b exp 1", bus.rsp_valid); end
    vectors++; if (bus.rsp_tag !== 15'h12) begin miscompares++; $display("FAIL read_rsp_tag got %h exp 12", bus.rsp_tag); end
    vectors++; if (bus.rsp_data !== rd) begin miscompares++; $display("FAIL read_rsp_data got %h exp %h", bus.rsp_data, rd); end
    tick();
    m_valid[id] = 0;
    idle();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_clear got %b exp 0", busy); end
  endtask

  task automatic test_write();
    logic [15:0]  be [2];
    logic [2:0]   op [2];
    logic [127:0] wd;
    int id;
    be[0] = 16'hFFFF; be[1] = 16'h000F; op[0] = 3'd0; op[1] = 3'd1;
    idle();
    bus.a_ready = 1;
    for (int k = 0; k < 2; k++) begin
      id = lowest_free();
      wd = rnd128();
      bus.req_valid = 1; bus.req_rw = 1; bus.req_byteen = be[k];
      bus.req_addr = 28'($urandom); bus.req_data = wd; bus.req_tag = 15'(k + 7);
      #1;
      vectors++; if (bus.a_opcode !== op[k]) begin miscompares++; $display("FAIL write_opcode%0d got %0d exp %0d", k, bus.a_opcode, op[k]); end
      vectors++; if (bus.a_mask !== be[k]) begin miscompares++; $display("FAIL write_mask%0d got %h exp %h", k, bus.a_mask, be[k]); end
      vectors++; if (bus.a_data !== wd) begin miscompares++; $display("FAIL write_data%0d got %h exp %h", k, bus.a_data, wd); end
      vectors++; if (bus.a_source !== 3'(id)) begin miscompares++; $display("FAIL write_source%0d got %0d exp %0d", k, bus.a_source, id); end
      tick();
      model_alloc(id, 15'(k + 7), 1);
    end
    idle();
    for (int k = 1; k >= 0; k--) begin
      bus.d_valid = 1; bus.d_opcode = 0; bus.d_source = 3'(k); bus.rsp_ready = 0;
      #1;
      vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ack_rsp_valid%0d got %b exp 0", k, bus.rsp_valid); end
      vectors++; if (bus.d_ready !== 1'b1) begin miscompares++; $display("FAIL ack_d_ready%0d got %b exp 1", k, bus.d_ready); end
      tick();
      m_valid[k] = 0;
    end
    idle();
    #1;
    vectors++; if (busy !== any_busy()) begin miscompares++; $display("FAIL write_busy got %b exp %b", busy, any_busy()); end
  endtask

  task automatic test_full();
    int id;
    idle();
    bus.a_ready = 1; bus.rsp_ready = 1;
    for (int i = 0; i < NS; i++) begin
      id = lowest_free();
      drive_read(28'(i), 15'(16'h100 + i));
      #1;
      vectors++; if (bus.req_ready !== 1'b1 || bus.a_source !== 3'(id)) begin miscompares++; $display("FAIL full_fill%0d got ready %b src %0d exp ready 1 src %0d", i, bus.req_ready, bus.a_source, id); end
      tick();
      model_alloc(id, 15'(16'h100 + i), 0);
    end
    drive_read(28'h99, 15'h1FF);
    #1;
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %b exp 0", bus.req_ready); end
    vectors++; if (bus.a_valid !== 1'b0) begin miscompares++; $display("FAIL full_a_valid got %b exp 0", bus.a_valid); end
    bus.d_valid = 1; bus.d_opcode = 1; bus.d_source = 3'd5; bus.d_data = rnd128();
    #1;
    vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL full_same_cycle_reuse got %b exp 0", bus.req_ready); end
    vectors++; if (bus.rsp_tag !== m_tag[5]) begin miscompares++; $display("FAIL full_tag5 got %h exp %h", bus.rsp_tag, m_tag[5]); end
    tick();
    m_valid[5] = 0;
    bus.d_valid = 0;
    #1;
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL full_ninth_ready got %b exp 1", bus.req_ready); end
    vectors++; if (bus.a_source !== 3'd5) begin miscompares++; $display("FAIL full_ninth_source got %0d exp 5", bus.a_source); end
    tick();
    model_alloc(5, 15'h1FF, 0);
    idle();
  endtask

  task automatic test_out_of_order();
    int order [NS] = '{3, 0, 7, 1, 2, 4, 5, 6};
    int s;
    logic [127:0] rd;
    idle();
    for (int k = 0; k < NS; k++) begin
      s = order[k];
      rd = rnd128();
      bus.d_valid = 1; bus.d_opcode = 1; bus.d_source = 3'(s); bus.d_data = rd; bus.rsp_ready = 0;
      #1;
      vectors++; if (bus.rsp_valid !== 1'b1 || bus.d_ready !== 1'b0) begin miscompares++; $display("FAIL ooo_stall_src%0d got valid %b dready %b exp 1 0", s, bus.rsp_valid, bus.d_ready); end
      vectors++; if (bus.rsp_tag !== m_tag[s]) begin miscompares++; $display("FAIL ooo_tag_stall_src%0d got %h exp %h", s, bus.rsp_tag, m_tag[s]); end
      tick();
      bus.rsp_ready = 1;
      #1;
      vectors++; if (bus.d_ready !== 1'b1) begin miscompares++; $display("FAIL ooo_dready_src%0d got %b exp 1", s, bus.d_ready); end
      vectors++; if (bus.rsp_tag !== m_tag[s] || bus.rsp_data !== rd) begin miscompares++; $display("FAIL ooo_rsp_src%0d got tag %h exp %h", s, bus.rsp_tag, m_tag[s]); end
      tick();
      m_valid[s] = 0;
    end
    idle();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ooo_busy got %b exp 0", busy); end
  endtask

  task automatic test_error();
    idle();
    bus.a_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive_read(28'(i), 15'(i));
      tick();
    end
    idle();
    do_reset(1);
    bus.d_valid = 1; bus.d_opcode = 1; bus.d_source = 3'd2; bus.rsp_ready = 0;
    #1;
    vectors++; if (bus.d_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL stale_drop got dready %b valid %b exp 1 0", bus.d_ready, bus.rsp_valid); end
    tick();
    idle();
    #1;
    vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL stale_err got %b exp 1", err_sticky); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stale_busy got %b exp 0", busy); end
    do_reset(1);
    #1;
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL err_clear got %b exp 0", err_sticky); end
    bus.a_ready = 1;
    drive_read(28'h77, 15'h2A);
    tick();
    model_alloc(0, 15'h2A, 0);
    idle();
    bus.d_valid = 1; bus.d_opcode = 1; bus.d_source = 3'd0; bus.d_denied = 1; bus.rsp_ready = 1;
    #1;
    vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 15'h2A) begin miscompares++; $display("FAIL denied_fwd got valid %b tag %h exp 1 2a", bus.rsp_valid, bus.rsp_tag); end
    tick();
    m_valid[0] = 0;
    idle();
    #1;
    vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL denied_err got %b exp 1", err_sticky); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL denied_busy got %b exp 0", busy); end
  endtask

  // IRQ expected high at cycle c iff a rising msip edge occurred within the last PULSE cycles.
  task automatic run_irq(input logic [31:0] pat, input string name);
    bit edge_at [32];
    bit exp_irq;
    int highs, exp_highs;
    highs = 0; exp_highs = 0;
    msip = 0;
    repeat (PULSE + 2) tick();
    for (int c = 0; c < 32; c++) edge_at[c] = pat[c] && !(c > 0 && pat[c-1]);
    for (int c = 0; c < 32; c++) begin
      msip = pat[c];
      tick();
      exp_irq = 0;
      for (int j = c - PULSE + 1; j <= c; j++) if (j >= 0 && edge_at[j]) exp_irq = 1;
      if (irq_out) highs++;
      if (exp_irq) exp_highs++;
      vectors++; if (irq_out !== exp_irq) begin miscompares++; $display("FAIL irq_%s_cycle%0d got %b exp %b", name, c, irq_out, exp_irq); end
    end
    vectors++; if (highs != exp_highs) begin miscompares++; $display("FAIL irq_%s_total got %0d exp %0d", name, highs, exp_highs); end
    msip = 0;
  endtask

  task automatic test_irq();
    run_irq(32'h0000_03FF, "single");
    run_irq(32'h0000_0009, "retrigger");
    run_irq($urandom & 32'h00FF_FFFF, "random");
  endtask

  task automatic test_random();
    int lf, s;
    int out_q [$];
    bit exp_rr, exp_av, exp_dr;
    logic [127:0] rd;
    logic [2:0] exp_op;
    idle();
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      bus.req_valid = ($urandom_range(0, 9) < 6);
      bus.req_rw = 1'($urandom);
      bus.req_byteen = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      bus.req_addr = 28'($urandom); bus.req_tag = 15'($urandom); bus.req_data = rnd128();
      bus.a_ready = ($urandom_range(0, 3) != 0);
      bus.rsp_ready = 1'($urandom);
      out_q.delete();
      for (int i = 0; i < NS; i++) if (m_valid[i]) out_q.push_back(i);
      bus.d_valid = (out_q.size() > 0) && ($urandom_range(0, 1) == 1);
      s = (out_q.size() > 0) ? out_q[$urandom_range(0, out_q.size() - 1)] : 0;
      rd = rnd128();
      bus.d_source = 3'(s); bus.d_opcode = m_rw[s] ? 3'd0 : 3'd1; bus.d_data = rd;
      #1;
      lf = lowest_free();
      exp_av = bus.req_valid && lf >= 0;
      exp_rr = bus.a_ready && lf >= 0;
      exp_op = bus.req_rw ? ((bus.req_byteen == 16'hFFFF) ? 3'd0 : 3'd1) : 3'd4;
      vectors++; if (bus.a_valid !== exp_av || bus.req_ready !== exp_rr) begin miscompares++; $display("FAIL rnd%0d_hs got av %b rr %b exp %b %b", n, bus.a_valid, bus.req_ready, exp_av, exp_rr); end
      if (exp_av) begin
        vectors++; if (bus.a_source !== 3'(lf) || bus.a_opcode !== exp_op || bus.a_address !== {bus.req_addr, 4'h0} || bus.a_mask !== (bus.req_rw ? bus.req_byteen : 16'hFFFF)) begin miscompares++; $display("FAIL rnd%0d_a got src %0d op %0d exp src %0d op %0d", n, bus.a_source, bus.a_opcode, lf, exp_op); end
      end
      vectors++; if (busy !== (out_q.size() > 0)) begin miscompares++; $display("FAIL rnd%0d_busy got %b exp %b", n, busy, out_q.size() > 0); end
      exp_dr = m_rw[s] ? 1'b1 : bus.rsp_ready;
      if (bus.d_valid) begin
        vectors++; if (bus.d_ready !== exp_dr || bus.rsp_valid !== !m_rw[s]) begin miscompares++; $display("FAIL rnd%0d_d got dready %b rv %b exp %b %b", n, bus.d_ready, bus.rsp_valid, exp_dr, !m_rw[s]); end
        if (!m_rw[s]) begin
          vectors++; if (bus.rsp_tag !== m_tag[s] || bus.rsp_data !== rd) begin miscompares++; $display("FAIL rnd%0d_rsp got tag %h exp %h", n, bus.rsp_tag, m_tag[s]); end
        end
      end else begin
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_idle_rsp got %b exp 0", n, bus.rsp_valid); end
      end
      tick();
      if (bus.d_valid && exp_dr) m_valid[s] = 0;
      if (bus.req_valid && exp_rr) model_alloc(lf, bus.req_tag, bus.req_rw);
    end
    idle();
    #1;
    vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL rnd_err got %b exp 0", err_sticky); end
  endtask

  initial begin
    reset = 1; msip = 0;
    idle();
    test_reset();
    test_read();
    test_write();
    test_full();
    test_out_of_order();
    test_error();
    test_irq();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
